// File: rtl/hilo_mdu_ctrl_if.sv
// Issue-bundle and HI/LO write-port bundle between the dual-issue pipeline
// and the multiply/divide sequencer.
interface hilo_mdu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [2:0]  op_1;
  logic [2:0]  op_2;
  logic [31:0] rs_1;
  logic [31:0] rt_1;
  logic [31:0] rs_2;
  logic [31:0] rt_2;
  logic        hi_w_en_1;
  logic        hi_w_en_2;
  logic        lo_w_en_1;
  logic        lo_w_en_2;
  logic [31:0] hi_w_data_1;
  logic [31:0] hi_w_data_2;
  logic [31:0] lo_w_data_1;
  logic [31:0] lo_w_data_2;
  logic        busy;

  modport master (
    output in_valid, flush, op_1, op_2, rs_1, rt_1, rs_2, rt_2,
    input  in_ready, busy,
    input  hi_w_en_1, hi_w_en_2, lo_w_en_1, lo_w_en_2,
    input  hi_w_data_1, hi_w_data_2, lo_w_data_1, lo_w_data_2
  );

  modport slave (
    input  in_valid, flush, op_1, op_2, rs_1, rt_1, rs_2, rt_2,
    output in_ready, busy,
    output hi_w_en_1, hi_w_en_2, lo_w_en_1, lo_w_en_2,
    output hi_w_data_1, hi_w_data_2, lo_w_data_1, lo_w_data_2
  );
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// Multiply/divide sequencer and HI/LO write scheduler: 2-cycle multiply,
// restoring divider, MTHI/MTLO bypass and in-bundle write masking.
module hilo_mdu_ctrl #(
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            reset,
  hilo_mdu_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_e;

  function automatic logic is_mdu(input op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  op_e op_1, op_2;
  assign op_1 = op_e'(bus.op_1);
  assign op_2 = op_e'(bus.op_2);

  state_e           state;
  logic             pend_valid;
  op_e              pend_op;
  logic [31:0]      pend_rs, pend_rt;
  logic             act_slot2, act_mask_hi, act_mask_lo, act_signed;
  logic [31:0]      act_rs, act_rt;
  logic [31:0]      div_rem, div_quo, div_dvs;
  logic             div_neg_q, div_neg_r;
  logic [CNT_W-1:0] div_cnt;

  logic accept;
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  // Launch source: a fresh bundle from IDLE, or the held slot-2 op from WB.
  logic        l_valid, l_slot2, l_mask_hi, l_mask_lo;
  op_e         l_op;
  logic [31:0] l_rs, l_rt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    l_valid   = 1'b0;
    l_slot2   = 1'b0;
    l_mask_hi = 1'b0;
    l_mask_lo = 1'b0;
    l_op      = op_1;
    l_rs      = bus.rs_1;
    l_rt      = bus.rt_1;
    if (accept) begin
      if (is_mdu(op_1)) begin
        l_valid   = 1'b1;
        l_mask_hi = (op_2 == OP_MTHI);
        l_mask_lo = (op_2 == OP_MTLO);
      end else if (is_mdu(op_2)) begin
        l_valid = 1'b1;
        l_slot2 = 1'b1;
        l_op    = op_2;
        l_rs    = bus.rs_2;
        l_rt    = bus.rt_2;
      end
    end else if (state == S_WB && pend_valid && !bus.flush) begin
      l_valid = 1'b1;
      l_slot2 = 1'b1;
      l_op    = pend_op;
      l_rs    = pend_rs;
      l_rt    = pend_rt;
    end
  end

  logic        l_signed, l_div, l_dvz;
  logic [31:0] l_rs_abs, l_rt_abs;
  assign l_signed = (l_op == OP_MULT) || (l_op == OP_DIV);
  assign l_div    = (l_op == OP_DIV) || (l_op == OP_DIVU);
  assign l_dvz    = l_div && (l_rt == 32'd0);
  assign l_rs_abs = (l_signed && l_rs[31]) ? -l_rs : l_rs;
  assign l_rt_abs = (l_signed && l_rt[31]) ? -l_rt : l_rt;

  // One 64x64 multiplier covers both flavours: only the extension differs.
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = {{32{act_signed & act_rs[31]}}, act_rs};
  assign mul_b   = {{32{act_signed & act_rt[31]}}, act_rt};
  assign product = mul_a * mul_b;

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  logic [32:0] rem_shift, rem_diff;
  logic        div_done;
  assign rem_shift = {div_rem, div_quo[31]};
  assign rem_diff  = rem_shift - {1'b0, div_dvs};
  assign div_done  = (state == S_DIV) && (div_cnt == CNT_W'(DIV_ITERS));

  logic        res_fire;
  logic [31:0] res_hi, res_lo;
  assign res_fire = (state == S_MUL) || div_done;
  assign res_hi   = (state == S_MUL) ? product[63:32] : (div_neg_r ? -div_rem : div_rem);
  assign res_lo   = (state == S_MUL) ? product[31:0]  : (div_neg_q ? -div_quo : div_quo);

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block take precedence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      bus.in_ready    <= 1'b1;
      bus.busy        <= 1'b0;
      pend_valid      <= 1'b0;
      act_slot2       <= 1'b0;
      act_mask_hi     <= 1'b0;
      act_mask_lo     <= 1'b0;
      div_cnt         <= '0;
      bus.hi_w_en_1   <= 1'b0;
      bus.hi_w_en_2   <= 1'b0;
      bus.lo_w_en_1   <= 1'b0;
      bus.lo_w_en_2   <= 1'b0;
      bus.hi_w_data_1 <= '0;
      bus.hi_w_data_2 <= '0;
      bus.lo_w_data_1 <= '0;
      bus.lo_w_data_2 <= '0;
    end else begin
      bus.hi_w_en_1 <= 1'b0;
      bus.hi_w_en_2 <= 1'b0;
      bus.lo_w_en_1 <= 1'b0;
      bus.lo_w_en_2 <= 1'b0;
      if (bus.flush) begin
        state        <= S_IDLE;
        bus.in_ready <= 1'b1;
        bus.busy     <= 1'b0;
        pend_valid   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            if (op_1 == OP_MTHI) begin bus.hi_w_en_1 <= 1'b1; bus.hi_w_data_1 <= bus.rs_1; end
            if (op_1 == OP_MTLO) begin bus.lo_w_en_1 <= 1'b1; bus.lo_w_data_1 <= bus.rs_1; end
            if (op_2 == OP_MTHI) begin bus.hi_w_en_2 <= 1'b1; bus.hi_w_data_2 <= bus.rs_2; end
            if (op_2 == OP_MTLO) begin bus.lo_w_en_2 <= 1'b1; bus.lo_w_data_2 <= bus.rs_2; end
            pend_valid <= is_mdu(op_1) && is_mdu(op_2);
          end
          S_MUL: ;
          S_DIV: if (!div_done) div_cnt <= div_cnt + CNT_W'(1);
          S_WB: begin
            pend_valid <= 1'b0;
            if (!pend_valid) begin
              state        <= S_IDLE;
              bus.in_ready <= 1'b1;
              bus.busy     <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase

        if (res_fire) begin
          state <= S_WB;
          if (!act_slot2) begin
            if (!act_mask_hi) begin bus.hi_w_en_1 <= 1'b1; bus.hi_w_data_1 <= res_hi; end
            if (!act_mask_lo) begin bus.lo_w_en_1 <= 1'b1; bus.lo_w_data_1 <= res_lo; end
          end else begin
            if (!act_mask_hi) begin bus.hi_w_en_2 <= 1'b1; bus.hi_w_data_2 <= res_hi; end
            if (!act_mask_lo) begin bus.lo_w_en_2 <= 1'b1; bus.lo_w_data_2 <= res_lo; end
          end
        end

        // Divide by zero skips straight to WB, where no pulse is ever raised.
        if (l_valid) begin
          state        <= l_dvz ? S_WB : (l_div ? S_DIV : S_MUL);
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b1;
          act_slot2    <= l_slot2;
          act_mask_hi  <= l_mask_hi;
          act_mask_lo  <= l_mask_lo;
          div_cnt      <= '0;
        end
      end
    end
  end

  // NOTE: operand/datapath registers carry no reset; control flops above decide whether they are ever used.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_op <= op_2;
      pend_rs <= bus.rs_2;
      pend_rt <= bus.rt_2;
    end
    if (l_valid) begin
      act_rs     <= l_rs;
      act_rt     <= l_rt;
      act_signed <= l_signed;
      div_rem    <= '0;
      div_quo    <= l_rs_abs;
      div_dvs    <= l_rt_abs;
      div_neg_q  <= l_signed && (l_rs[31] ^ l_rt[31]);
      div_neg_r  <= l_signed && l_rs[31];
    end else if (state == S_DIV && !div_done) begin
      div_rem <= rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
      div_quo <= {div_quo[30:0], ~rem_diff[32]};
    end
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
# hilo_mdu_ctrl

Multiply/divide sequencer and HI/LO write scheduler for the dual-issue integer pipeline. Accepts an issue bundle of up to two HI/LO-affecting instructions (slot 1 older, slot 2 younger), runs MULT/MULTU in a 2-cycle pipeline and DIV/DIVU on a 32-iteration restoring divider, and drives the two write ports of the HI and LO register instances. Port 2 of each register has write priority, so program order is preserved when both ports fire together. Stalls issue while an MDU operation is in flight.

## Interface
Parameters:
- DIV_ITERS, 32, divider iterations; fixed by the 32-bit operand width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  bundle present.
- in_ready  out  1  controller can accept a bundle.
- flush  in  1  cancel in-flight and pending operations.
- op_1, op_2  in  3 each  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NOP.
- rs_1, rt_1, rs_2, rt_2  in  32 each  operands per slot.
- hi_w_en_1, hi_w_en_2, lo_w_en_1, lo_w_en_2  out  1 each  single-cycle write pulses to the HI/LO register ports.
- hi_w_data_1, hi_w_data_2, lo_w_data_1, lo_w_data_2  out  32 each  write data.
- busy  out  1  MDU operation in flight or pending; equals !in_ready.

## Operation
- States: IDLE, MUL, DIV, WB.
- Accept occurs when in_valid && in_ready. in_ready = 1 only in IDLE with no pending op.
- MTHI/MTLO in slot k: write rs_k on the HI or LO port k in the cycle after accept. This is independent of the FSM and does not drop in_ready.
- MDU op (codes 1–4) in slot k: capture rs_k, rt_k, the op, and the slot. The FSM goes to MUL or DIV.
- Both slots MDU: slot 1 runs first. Slot 2's operands are held in a pending register, and slot 2 starts in the cycle slot 1 enters WB.
- Ordering within a bundle: if slot 1 is MDU and slot 2 is MTHI (or MTLO), the MDU write to HI (or LO) is suppressed. The other half is still written. If slot 1 is MT and slot 2 is MDU, no masking is applied; the later MDU write wins naturally.
- MUL: the 64-bit product is registered. MULT is signed and MULTU unsigned. HI = product[63:32], LO = product[31:0]. Transition to WB.
- DIV:
  - Operate on absolute values for DIV, then run DIV_ITERS restoring iterations.
  - Sign fix: quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - Transition to WB. 0x80000000 / -1 yields LO = 0x80000000, HI = 0.
- Divide by zero (rt = 0, DIV or DIVU): no iterations and no write. The FSM goes straight to WB with write enables suppressed.
- WB: pulse hi_w_en_k and lo_w_en_k on the issuing slot's port, minus any masked half. Then go to IDLE, or to MUL/DIV if an op is pending.
- flush: next state is IDLE. Pending and in-flight ops are discarded. Any write pulse scheduled for the same edge is suppressed.
- Reset values: state IDLE, in_ready 1, busy 0. All w_en = 0, all w_data = 0, pending cleared.

## Timing
- All outputs are registered. Accept edge is T.
- MT write: pulse at cycle T+1.
- MULT/MULTU: MUL at T+1, write pulse at T+2, in_ready = 1 at T+3.
- DIV/DIVU: DIV occupies T+1..T+33 (32 iterations plus the sign fix). Write pulse at T+34, in_ready = 1 at T+35.
- Divide by zero: WB at T+1 with no pulse, in_ready = 1 at T+2.
- Dual MDU: the second op starts on the cycle of the first write. Example: MULT+MULT writes slot 1 at T+2, slot 2 at T+4, and in_ready = 1 at T+5.
- Both ports may pulse in the same cycle only for a dual MT bundle; port 2 wins in the register.
- Asynchronous reset mid-operation: all state and outputs take reset values immediately. No write pulse is produced after reset releases.

## Test plan
- MULT slot 1: rs = 0xFFFFFFFE, rt = 3 → at T+2, hi_w_en_1 = lo_w_en_1 = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV slot 2: rs = −7, rt = 2 → at T+34 on port 2, LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. busy is high from T+1 to T+34.
- DIVU with rt = 0 → no write enable ever pulses; in_ready = 1 at T+2.
- Bundle slot 1 MULT (5×6), slot 2 MTHI 0xAAAA5555 → at T+1, hi_w_en_2 with 0xAAAA5555. At T+2, lo_w_en_1 with LO = 30 and no HI write.
- Bundle slot 1 DIVU 100/7, slot 2 MULTU 4×4 → T+34 port 1: LO = 14, HI = 2. T+36 port 2: LO = 16, HI = 0.
- DIV accepted, then flush at T+10 → no write pulses, in_ready = 1 at T+11. A separate run with reset asserted at T+5 → all outputs at reset values immediately and no later write.
